// File: rtl/sound_gen_multi.sv
// rtl/sound_gen_multi.sv - multi-channel square/LFO/noise sound generator with one-shot gate
module sound_gen_multi #(
  parameter int          NUM_VCO   = 4,
  parameter int          FREQ_W    = 12,
  parameter int          LFO_W     = 10,
  parameter int          PRESCALE  = 16,
  parameter logic [15:0] LFSR_POLY = 16'h100B,
  parameter int          LEN_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_VCO*FREQ_W-1:0] vco_freq,
  input  logic [NUM_VCO-1:0]        vco_lfo_en,
  input  logic [LFO_W-1:0]          lfo_freq,
  input  logic [2:0]                lfo_shift,
  input  logic [FREQ_W-1:0]         noise_freq,
  input  logic                      noise_lfo_en,
  input  logic [NUM_VCO+1:0]        mixer,
  input  logic [1:0]                mix_mode,
  input  logic                      oneshot_en,
  input  logic [LEN_W-1:0]          oneshot_len,
  input  logic                      trigger,
  output logic                      spkr,
  output logic                      busy
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int LFO_CW = LFO_W + 8;
  localparam int SRC_W  = NUM_VCO + 2;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic              tick_q;

  logic [LFO_CW-1:0] lfo_cnt;
  logic              lfo_state;
  logic [FREQ_W-1:0] tri_wave;
  logic [FREQ_W-1:0] delta;

  logic [FREQ_W:0]   vco_cnt    [NUM_VCO];
  logic [FREQ_W:0]   vco_reload [NUM_VCO];
  logic [NUM_VCO-1:0] vco_state;

  logic [FREQ_W:0]   noise_cnt;
  logic [FREQ_W:0]   noise_reload;
  logic              noise_state;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;

  logic [SRC_W-1:0]  src;
  logic              mix;

  logic [0:0]        os_state;
  logic [LEN_W-1:0]  len_cnt;

  assign tick = (pre_cnt == PRE_LAST);

  // Prescaler: free-running 0..PRESCALE-1, tick on the last count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Delayed tick so spkr samples the source states updated on the tick itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
    end
  end

  // Triangle from the top FREQ_W bits of the LFO counter, scaled by the depth shift.
  always_comb begin
    tri_wave = lfo_cnt[LFO_CW-1] ? ~lfo_cnt[LFO_CW-1 -: FREQ_W] : lfo_cnt[LFO_CW-1 -: FREQ_W];
    delta    = tri_wave >> lfo_shift;
  end

  // LFO: half-period {lfo_freq,8'b0}+1 ticks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfo_cnt   <= '0;
      lfo_state <= 1'b0;
    end else if (tick) begin
      if (lfo_cnt == '0) begin
        lfo_state <= ~lfo_state;
        lfo_cnt   <= {lfo_freq, 8'b0};
      end else begin
        lfo_cnt <= lfo_cnt - LFO_CW'(1);
      end
    end
  end

  // Per-VCO reload, one bit wider than the frequency so modulation never wraps.
  always_comb begin
    for (int i = 0; i < NUM_VCO; i++) begin
      vco_reload[i] = {1'b0, vco_freq[i*FREQ_W +: FREQ_W]} + (vco_lfo_en[i] ? {1'b0, delta} : '0);
    end
  end

  // VCO bank: toggle and reload at zero, otherwise count down.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VCO; i++) begin
        vco_cnt[i] <= '0;
      end
      vco_state <= '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_VCO; i++) begin
        if (vco_cnt[i] == '0) begin
          vco_state[i] <= ~vco_state[i];
          vco_cnt[i]   <= vco_reload[i];
        end else begin
          vco_cnt[i] <= vco_cnt[i] - (FREQ_W+1)'(1);
        end
      end
    end
  end

  // Galois LFSR step (left-shifting, feedback from bit 15) and modulated noise reload.
  always_comb begin
    lfsr_next    = {lfsr[14:0], 1'b0} ^ (lfsr[15] ? LFSR_POLY : 16'h0000);
    noise_reload = {1'b0, noise_freq} + (noise_lfo_en ? {1'b0, delta} : '0);
  end

  // Noise: at each resample the output flips when the outgoing LFSR bit 0 is set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      noise_cnt   <= '0;
      noise_state <= 1'b0;
      lfsr        <= 16'h0001;
    end else if (tick) begin
      if (noise_cnt == '0) begin
        lfsr      <= lfsr_next;
        noise_cnt <= noise_reload;
        if (lfsr[0]) begin
          noise_state <= ~noise_state;
        end
      end else begin
        noise_cnt <= noise_cnt - (FREQ_W+1)'(1);
      end
    end
  end

  // Mixer: disabled sources are neutral for AND/OR/XOR; nothing enabled gives silence.
  always_comb begin
    src = {lfo_state, noise_state, vco_state};
    mix = 1'b0;
    if (mixer != '0) begin
      case (mix_mode)
        2'd1:    mix = |(src & mixer);
        2'd2:    mix = ^(src & mixer);
        default: mix = &(src | ~mixer);
      endcase
    end
  end

  // One-shot: trigger evaluated every clk, length counted in ticks; retrigger beats expiry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      os_state <= ST_IDLE;
      len_cnt  <= '0;
    end else begin
      case (os_state)
        ST_IDLE: begin
          if (trigger && (oneshot_len != '0)) begin
            os_state <= ST_ACTIVE;
            len_cnt  <= oneshot_len;
          end
        end
        default: begin
          if (trigger && (oneshot_len != '0)) begin
            len_cnt <= oneshot_len;
          end else if (tick) begin
            if (len_cnt == LEN_W'(1)) begin
              os_state <= ST_IDLE;
              len_cnt  <= '0;
            end else begin
              len_cnt <= len_cnt - LEN_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign busy = (os_state == ST_ACTIVE);

  // Speaker: mixed sources gated by the one-shot, refreshed once per tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      spkr <= 1'b0;
    end else if (tick_q) begin
      spkr <= mix & (~oneshot_en | busy);
    end
  end

endmodule

// File: tb/tb_sound_gen_multi.sv
// tb/tb_sound_gen_multi.sv - scoreboard bench for sound_gen_multi
module tb_sound_gen_multi;

  logic        clk;
  logic        reset;
  logic [47:0] vco_freq;
  logic [3:0]  vco_lfo_en;
  logic [9:0]  lfo_freq;
  logic [2:0]  lfo_shift;
  logic [11:0] noise_freq;
  logic        noise_lfo_en;
  logic [5:0]  mixer;
  logic [1:0]  mix_mode;
  logic        oneshot_en;
  logic [15:0] oneshot_len;
  logic        trigger;
  logic        spkr;
  logic        busy;

  sound_gen_multi dut (
    .clk          (clk),
    .reset        (reset),
    .vco_freq     (vco_freq),
    .vco_lfo_en   (vco_lfo_en),
    .lfo_freq     (lfo_freq),
    .lfo_shift    (lfo_shift),
    .noise_freq   (noise_freq),
    .noise_lfo_en (noise_lfo_en),
    .mixer        (mixer),
    .mix_mode     (mix_mode),
    .oneshot_en   (oneshot_en),
    .oneshot_len  (oneshot_len),
    .trigger      (trigger),
    .spkr         (spkr),
    .busy         (busy)
  );

  typedef struct {
    logic spkr;
    logic busy;
    logic chk_busy;
    int   tick;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    n;
  int    n_pass;
  int    n_total;
  string cur_test;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks since reset release, mirroring the prescaler phase.
  always @(posedge clk) n <= reset ? n + 1 : 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: one scoreboard entry per tick, sampled the clk after the tick.
  always @(negedge clk) begin
    if (reset && n > 1 && (n % 16) == 1 && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk($sformatf("%s_spkr_t%0d", cur_test, mon_e.tick), spkr, mon_e.spkr);
      if (mon_e.chk_busy) chk($sformatf("%s_busy_t%0d", cur_test, mon_e.tick), busy, mon_e.busy);
    end
  end

  task automatic push(input logic s, input logic b, input logic cb, input int t);
    exp_t e;
    e.spkr = s; e.busy = b; e.chk_busy = cb; e.tick = t;
    sb.push_back(e);
  endtask

  task automatic set_defaults();
    vco_freq = '0; vco_lfo_en = '0; lfo_freq = '0; lfo_shift = '0;
    noise_freq = '0; noise_lfo_en = 1'b0; mixer = '0; mix_mode = 2'd0;
    oneshot_en = 1'b0; oneshot_len = '0; trigger = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    set_defaults();
  endtask

  task automatic wait_n(input int target);
    int k;
    k = 0;
    while (n != target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (n != target) begin
      n_total++;
      $display("FAIL %s_wait_n: reached %0d required %0d", cur_test, n, target);
    end
  endtask

  task automatic drain();
    int k;
    int lim;
    k = 0;
    lim = sb.size() * 16 + 64;
    while (sb.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL %s_drain: %0d entries left required 0", cur_test, sb.size());
      sb.delete();
    end
  endtask

  function automatic logic sq(input int t, input int h);
    return (((t - 1) / h + 1) % 2) == 1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] s;
    s = {l[14:0], 1'b0};
    if (l[15]) s = s ^ 16'h100B;
    return s;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, b, s, ns;
    logic [15:0] l;
    int togg;
    int modes [4];
    int k;
    modes = '{2, 1, 0, 3};
    n_pass = 0; n_total = 0; n = 0;
    reset = 1'b0;
    set_defaults();

    // Reset state
    cur_test = "reset";
    do_reset();
    chk("reset_spkr", spkr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_lfsr", dut.lfsr, 16'h0001);

    // 1: single VCO, half-period 4 ticks, first rise 17 clk after release
    cur_test = "t1";
    vco_freq = {36'd0, 12'd3}; mixer = 6'b000001; mix_mode = 2'd0;
    for (int t = 1; t <= 16; t++) push(sq(t, 4), 1'b0, 1'b1, t);
    reset = 1'b1;
    k = 0;
    while (!spkr && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t1_first_rise_clk", n, 17);
    drain();

    // 2: two squares (periods 8 and 12 ticks) in XOR, OR, AND, reserved
    for (int m = 0; m < 4; m++) begin
      cur_test = $sformatf("t2_mode%0d", modes[m]);
      do_reset();
      vco_freq = {24'd0, 12'd5, 12'd3}; mixer = 6'b000011; mix_mode = 2'(modes[m]);
      for (int t = 1; t <= 48; t++) begin
        a = sq(t, 4); b = sq(t, 6);
        case (modes[m])
          2: s = a ^ b;
          1: s = a | b;
          default: s = a & b;
        endcase
        push(s, 1'b0, 1'b0, t);
      end
      reset = 1'b1;
      drain();
    end

    // 3a: VCO0 freq 2 with LFO modulation; delta is 3 from tick 4 onwards -> toggles at 1,4,10,16,22
    cur_test = "t3a";
    do_reset();
    vco_freq = {36'd0, 12'd2}; vco_lfo_en = 4'b0001; lfo_freq = 10'd1; lfo_shift = 3'd0;
    mixer = 6'b000001;
    togg = 0;
    for (int t = 1; t <= 24; t++) begin
      if (t == 1 || t == 4 || t == 10 || t == 16 || t == 22) togg++;
      push(togg[0], 1'b0, 1'b0, t);
    end
    reset = 1'b1;
    drain();

    // 3b/3c: reload 4095 + delta held in the wider counter (delta 2044, then 2044>>7 = 15)
    for (int sh = 0; sh < 2; sh++) begin
      cur_test = (sh == 0) ? "t3b" : "t3c";
      do_reset();
      vco_freq = '0; vco_lfo_en = 4'b0001; lfo_freq = 10'd511;
      lfo_shift = (sh == 0) ? 3'd0 : 3'd7;
      reset = 1'b1;
      wait_n(17);
      vco_freq = {36'd0, 12'd4095};
      wait_n(33);
      chk({cur_test, "_vco0_reload"}, dut.vco_cnt[0], (sh == 0) ? 6139 : 4110);
    end

    // 4: noise every tick vs software Galois model from seed 1
    cur_test = "t4";
    do_reset();
    noise_freq = '0; mixer = 6'b010000; mix_mode = 2'd1;
    l = 16'h0001; ns = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      if (l[0]) ns = ~ns;
      l = lfsr_step(l);
      push(ns, 1'b0, 1'b0, t);
    end
    reset = 1'b1;
    wait_n(1601);
    chk("t4_lfsr_100", dut.lfsr, l);
    drain();

    // 5a: one-shot len 10, trigger between ticks 2 and 3
    cur_test = "t5a";
    do_reset();
    vco_freq = {36'd0, 12'd4095}; mixer = 6'b000001; oneshot_en = 1'b1; oneshot_len = 16'd10;
    for (int t = 1; t <= 14; t++) push(t >= 3 && t <= 11, t >= 3 && t <= 11, 1'b1, t);
    reset = 1'b1;
    wait_n(33);
    trigger = 1'b1; @(negedge clk); trigger = 1'b0;
    drain();

    // 5b: retrigger after tick 8 extends expiry to tick 18
    cur_test = "t5b";
    do_reset();
    vco_freq = {36'd0, 12'd4095}; mixer = 6'b000001; oneshot_en = 1'b1; oneshot_len = 16'd10;
    for (int t = 1; t <= 20; t++) push(t >= 3 && t <= 17, t >= 3 && t <= 17, 1'b1, t);
    reset = 1'b1;
    wait_n(33);
    trigger = 1'b1; @(negedge clk); trigger = 1'b0;
    wait_n(129);
    trigger = 1'b1; @(negedge clk); trigger = 1'b0;
    drain();

    // 5c: trigger with zero length is ignored
    cur_test = "t5c";
    do_reset();
    vco_freq = {36'd0, 12'd4095}; mixer = 6'b000001; oneshot_en = 1'b1; oneshot_len = 16'd0;
    for (int t = 1; t <= 6; t++) push(1'b0, 1'b0, 1'b1, t);
    reset = 1'b1;
    wait_n(33);
    trigger = 1'b1; @(negedge clk); trigger = 1'b0;
    drain();

    // 6: reset mid one-shot and mid-LFSR, held across a tick boundary
    cur_test = "t6";
    do_reset();
    vco_freq = {36'd0, 12'd4095}; mixer = 6'b000001; oneshot_en = 1'b1; oneshot_len = 16'd1000;
    l = 16'h0001;
    for (int t = 1; t <= 5; t++) l = lfsr_step(l);
    reset = 1'b1;
    wait_n(33);
    trigger = 1'b1; @(negedge clk); trigger = 1'b0;
    wait_n(81);
    chk("t6_pre_spkr", spkr, 1);
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_lfsr", dut.lfsr, l);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_spkr", spkr, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_lfsr", dut.lfsr, 16'h0001);
    repeat (20) @(negedge clk);
    chk("t6_hold_vco_state", dut.vco_state, 0);
    chk("t6_hold_vco0_cnt", dut.vco_cnt[0], 0);
    chk("t6_hold_lfsr", dut.lfsr, 16'h0001);
    chk("t6_hold_spkr", spkr, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
